// File: rtl/bscan_pkg.sv
// rtl/bscan_pkg.sv - shared constants and types for the boundary-scan chain driver
//
// Purpose: command codes, FSM state encoding and TAP step counts used by
// bscan_chain_driver and its TCK generator.
// Ports: none (package).

package bscan_pkg;

  // Host command codes carried on CmdType
  localparam logic [1:0] CMD_TLR  = 2'b00;
  localparam logic [1:0] CMD_IR   = 2'b01;
  localparam logic [1:0] CMD_DR   = 2'b10;
  localparam logic [1:0] CMD_IDLE = 2'b11;

  // TMS=1 steps that guarantee Test-Logic-Reset from any TAP state
  localparam int TLR_STEPS    = 5;
  // Steps from Run-Test/Idle into Shift-IR / Shift-DR
  localparam int IR_PRE_STEPS = 4;
  localparam int DR_PRE_STEPS = 3;

  typedef enum logic [3:0] {
    S_RESET_SEQ,
    S_IDLE,
    S_TLR,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_RUN,
    S_ERR,
    S_RESP
  } state_t;

  // TMS for PRE step idx.
  // IR: RTI->SelDR->SelIR->CapIR->ShIR = 1,1,0,0
  // DR: RTI->SelDR->CapDR->ShDR       = 1,0,0
  function automatic logic pre_tms(input logic is_ir, input logic [1:0] idx);
    return is_ir ? (idx < 2'd2) : (idx == 2'd0);
  endfunction

endpackage

// File: rtl/tck_gen.sv
// rtl/tck_gen.sv - divided JTAG clock with rise/fall strobes
//
// Purpose: while en=1, toggles tck every DIV Clk cycles. rise/fall are
// combinational strobes high in the Clk cycle whose closing edge moves tck
// 0->1 / 1->0. When en=0 the counter clears and tck parks at 0.
// Ports:
//   Clk, ResetN   system clock, async active-low reset
//   en            run the divider
//   tck           JTAG clock
//   rise, fall    edge strobes (see above)

module tck_gen
  import bscan_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = en && (cnt == LAST);
  assign rise    = at_last && !tck;
  assign fall    = at_last && tck;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (at_last) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bscan_chain_driver.sv
// rtl/bscan_chain_driver.sv - JTAG master driving a TAP / boundary-scan chain
//
// Purpose: accepts one TLR, IR-scan, DR-scan or idle-clock command at a time,
// drives TCK/TMS/TDI and returns the captured TDO bits.
// Ports:
//   Clk, ResetN                 system clock, async active-low reset
//   CmdValid/CmdReady           command handshake
//   CmdType, CmdLen, CmdData    command code, length, TDI bits (LSB first)
//   RspValid, RspData, RspErr   1-cycle response pulse, captured TDO, length error
//   TCK, TMS, TDI, TDO          JTAG pins

module bscan_chain_driver
  import bscan_pkg::*;
#(
  parameter  int MAX_LEN = 32,
  parameter  int DIV     = 2,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               CmdValid,
  output logic               CmdReady,
  input  logic [1:0]         CmdType,
  input  logic [LW-1:0]      CmdLen,
  input  logic [MAX_LEN-1:0] CmdData,
  output logic               RspValid,
  output logic [MAX_LEN-1:0] RspData,
  output logic               RspErr,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int SW = LW + 3;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t             state;
  logic [SW-1:0]      step;
  logic [1:0]         typ;
  logic [LW-1:0]      len;
  logic [MAX_LEN-1:0] tdi_sr;
  logic [MAX_LEN-1:0] cap;
  logic               tck_en;
  logic               rise;
  logic               fall;

  logic [SW-1:0]      len_m1;
  logic [SW-1:0]      pre_last;
  logic               len_bad;

  assign len_m1   = SW'(len) - SW'(1);
  assign pre_last = (typ == CMD_IR) ? SW'(IR_PRE_STEPS - 1) : SW'(DR_PRE_STEPS - 1);
  // Checked on the live CmdLen so the decision is made in the accept cycle
  assign len_bad  = (CmdLen == '0) || (CmdLen > LW'(MAX_LEN));

  tck_gen #(.DIV(DIV)) u_tck_gen (
    .Clk    (Clk),
    .ResetN (ResetN),
    .en     (tck_en),
    .tck    (TCK),
    .rise   (rise),
    .fall   (fall)
  );

  // Every TAP step ends on a fall strobe; TMS/TDI for the next step are
  // loaded on that same edge so they are stable a full half-period before
  // the target samples them on the next TCK rise.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= S_RESET_SEQ;
      step     <= '0;
      typ      <= CMD_TLR;
      len      <= '0;
      tdi_sr   <= '0;
      cap      <= '0;
      tck_en   <= 1'b0;
      TMS      <= 1'b1;
      TDI      <= 1'b0;
      CmdReady <= 1'b0;
      RspValid <= 1'b0;
      RspErr   <= 1'b0;
      RspData  <= '0;
    end else begin
      case (state)
        // Shared walker for the post-reset sequence and the TLR command:
        // TLR_STEPS steps of TMS=1, then one TMS=0 step into Run-Test/Idle.
        S_RESET_SEQ, S_TLR: begin
          if (!tck_en) begin
            tck_en <= 1'b1;
          end else if (fall) begin
            if (step == SW'(TLR_STEPS)) begin
              tck_en <= 1'b0;
              step   <= '0;
              if (state == S_RESET_SEQ) begin
                state    <= S_IDLE;
                CmdReady <= 1'b1;
              end else begin
                state    <= S_RESP;
                RspValid <= 1'b1;
                RspData  <= '0;
              end
            end else begin
              step <= step + SW'(1);
              TMS  <= (step != SW'(TLR_STEPS - 1));
            end
          end
        end

        S_IDLE: begin
          if (CmdValid && CmdReady) begin
            CmdReady <= 1'b0;
            typ      <= CmdType;
            len      <= CmdLen;
            tdi_sr   <= CmdData;
            cap      <= '0;
            step     <= '0;
            RspErr   <= 1'b0;
            if (CmdType == CMD_TLR) begin
              state  <= S_TLR;
              TMS    <= 1'b1;
              tck_en <= 1'b1;
            end else if (len_bad) begin
              // No TCK activity; the ERR state is the response cycle
              state    <= S_ERR;
              RspValid <= 1'b1;
              RspErr   <= 1'b1;
              RspData  <= '0;
            end else begin
              tck_en <= 1'b1;
              TDI    <= 1'b0;
              if (CmdType == CMD_IDLE) begin
                state <= S_RUN;
                TMS   <= 1'b0;
              end else begin
                state <= S_PRE;
                TMS   <= 1'b1;
              end
            end
          end
        end

        S_PRE: begin
          if (fall) begin
            if (step == pre_last) begin
              state  <= S_SHIFT;
              step   <= '0;
              TMS    <= (len == LW'(1));
              TDI    <= tdi_sr[0];
              tdi_sr <= tdi_sr >> 1;
            end else begin
              step <= step + SW'(1);
              TMS  <= pre_tms(typ == CMD_IR, step[1:0] + 2'd1);
            end
          end
        end

        S_SHIFT: begin
          if (rise) begin
            cap[step[IW-1:0]] <= TDO;
          end
          if (fall) begin
            if (step == len_m1) begin
              // Last shift step left the TAP in Exit1; head for Update
              state <= S_POST;
              step  <= '0;
              TMS   <= 1'b1;
              TDI   <= 1'b0;
            end else begin
              step   <= step + SW'(1);
              TMS    <= ((step + SW'(1)) == len_m1);
              TDI    <= tdi_sr[0];
              tdi_sr <= tdi_sr >> 1;
            end
          end
        end

        // Exit1 -> Update (TMS=1) -> Run-Test/Idle (TMS=0)
        S_POST: begin
          if (fall) begin
            if (step == '0) begin
              step <= SW'(1);
              TMS  <= 1'b0;
            end else begin
              tck_en   <= 1'b0;
              step     <= '0;
              state    <= S_RESP;
              RspValid <= 1'b1;
              RspData  <= cap;
            end
          end
        end

        S_RUN: begin
          if (fall) begin
            if (step == len_m1) begin
              tck_en   <= 1'b0;
              step     <= '0;
              state    <= S_RESP;
              RspValid <= 1'b1;
              RspData  <= '0;
            end else begin
              step <= step + SW'(1);
            end
          end
        end

        // RspValid is high for exactly this cycle; ready returns on the next
        S_ERR, S_RESP: begin
          RspValid <= 1'b0;
          RspErr   <= 1'b0;
          CmdReady <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          state  <= S_RESET_SEQ;
          tck_en <= 1'b0;
          TMS    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bscan_chain_driver.sv
// tb/tb_bscan_chain_driver.sv - directed bench for bscan_chain_driver with a behavioural TAP target

module tb_bscan_chain_driver;

  localparam int MAX_LEN  = 32;
  localparam int DIV      = 3;
  localparam int LW       = 6;
  localparam int CLK_NS   = 10;
  localparam int STEP_CLK = 2 * DIV;

  localparam logic [1:0] C_TLR  = 2'b00;
  localparam logic [1:0] C_IR   = 2'b01;
  localparam logic [1:0] C_DR   = 2'b10;
  localparam logic [1:0] C_IDLE = 2'b11;

  logic               Clk;
  logic               ResetN;
  logic               CmdValid;
  logic               CmdReady;
  logic [1:0]         CmdType;
  logic [LW-1:0]      CmdLen;
  logic [MAX_LEN-1:0] CmdData;
  logic               RspValid;
  logic [MAX_LEN-1:0] RspData;
  logic               RspErr;
  logic               TCK;
  logic               TMS;
  logic               TDI;
  logic               TDO = 1'b0;

  bscan_chain_driver #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdType(CmdType), .CmdLen(CmdLen), .CmdData(CmdData),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural TAP target: 4-bit IR capturing 0001, 32-bit BSR capturing 0xDEADBEEF
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPDIR
  } tap_t;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDDR : T_PAUDR;
      T_PAUDR: return m ? T_EX2DR : T_PAUDR;
      T_EX2DR: return m ? T_UPDDR : T_SHDR;
      T_UPDDR: return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPDIR : T_PAUIR;
      T_PAUIR: return m ? T_EX2IR : T_PAUIR;
      T_EX2IR: return m ? T_UPDIR : T_SHIR;
      T_UPDIR: return m ? T_SELDR : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  tap_t        tap     = T_TLR;
  logic [31:0] dr_sr   = '0;
  logic [31:0] bsr_upd = '0;
  logic [3:0]  ir_sr   = '0;
  logic [3:0]  ir_upd  = '0;
  int          n_shift = 0;

  logic        tms_hist [0:1023];
  logic        tdi_hist [0:1023];
  time         rise_t   [0:1023];
  time         hi_w     [0:1023];
  logic [9:0]  n_rise = '0;
  int          n_rsp  = 0;

  always @(posedge TCK) begin
    case (tap)
      T_CAPDR: dr_sr <= 32'hDEADBEEF;
      T_SHDR: begin
        dr_sr   <= {TDI, dr_sr[31:1]};
        n_shift <= n_shift + 1;
      end
      T_UPDDR: bsr_upd <= dr_sr;
      T_CAPIR: ir_sr <= 4'b0001;
      T_SHIR:  ir_sr <= {TDI, ir_sr[3:1]};
      T_UPDIR: ir_upd <= ir_sr;
      default: ;
    endcase
    tap              <= tap_next(tap, TMS);
    tms_hist[n_rise] <= TMS;
    tdi_hist[n_rise] <= TDI;
    rise_t[n_rise]   <= $time;
    n_rise           <= n_rise + 10'd1;
  end

  always @(negedge TCK) begin
    TDO <= (tap == T_SHDR) ? dr_sr[0] : (tap == T_SHIR) ? ir_sr[0] : 1'b0;
    if (n_rise != 10'd0) hi_w[n_rise - 10'd1] <= $time - rise_t[n_rise - 10'd1];
  end

  always @(posedge Clk) if (RspValid) n_rsp <= n_rsp + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hist_vec(input logic sel_tdi, input logic [9:0] base, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v[6'(i)] = sel_tdi ? tdi_hist[base + 10'(i)] : tms_hist[base + 10'(i)];
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!CmdReady && k < 500) begin
      @(negedge Clk);
      k++;
    end
    expect_eq(tag, 64'(CmdReady), 64'd1);
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [LW-1:0] l, input logic [MAX_LEN-1:0] d,
                         output logic [MAX_LEN-1:0] rd, output logic re, output int cyc);
    @(negedge Clk);
    CmdType  = t;
    CmdLen   = l;
    CmdData  = d;
    CmdValid = 1'b1;
    wait_ready("cmd_accept");
    @(negedge Clk);
    CmdValid = 1'b0;
    expect_eq("busy_not_ready", 64'(CmdReady), 64'd0);
    cyc = 0;
    while (!RspValid && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
    end
    expect_eq("rsp_seen", 64'(RspValid), 64'd1);
    rd = RspData;
    re = RspErr;
    @(negedge Clk);
    expect_eq("rsp_one_cycle", 64'(RspValid), 64'd0);
    expect_eq("ready_after_rsp", 64'(CmdReady), 64'd1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [MAX_LEN-1:0] rd;
  logic               re;
  int                 cyc;
  logic [9:0]         base;
  int                 rsp0;
  int                 sh0;
  int                 bad;

  initial begin
    ResetN   = 1'b0;
    CmdValid = 1'b0;
    CmdType  = 2'b00;
    CmdLen   = '0;
    CmdData  = '0;
    repeat (3) @(negedge Clk);

    // Reset values and the automatic TLR -> RTI sequence
    expect_eq("rst_pins", 64'({TCK, TMS, TDI, CmdReady, RspValid, RspErr}), 64'b010000);
    expect_eq("rst_rspdata", 64'(RspData), 64'd0);
    base   = n_rise;
    rsp0   = n_rsp;
    ResetN = 1'b1;
    wait_ready("init_ready");
    expect_eq("init_tck_count", 64'(10'(n_rise - base)), 64'd6);
    expect_eq("init_tms", hist_vec(1'b0, base, 6), 64'h1F);
    expect_eq("init_no_rsp", 64'(n_rsp - rsp0), 64'd0);
    expect_eq("init_tap_rti", 64'(tap), 64'(T_RTI));

    // Explicit TLR command
    base = n_rise;
    run_cmd(C_TLR, 6'd0, 32'hFFFF_FFFF, rd, re, cyc);
    expect_eq("tlr_latency", 64'(cyc), 64'(6 * STEP_CLK));
    expect_eq("tlr_rsp", 64'({re, rd}), 64'd0);
    expect_eq("tlr_tms", hist_vec(1'b0, base, 6), 64'h1F);
    expect_eq("tlr_tap_rti", 64'(tap), 64'(T_RTI));

    // IR scan, L=4, TDI 0,1,0,1; IR captures 0001
    base = n_rise;
    run_cmd(C_IR, 6'd4, 32'hA, rd, re, cyc);
    expect_eq("ir_rspdata", 64'(rd), 64'h1);
    expect_eq("ir_rsperr", 64'(re), 64'd0);
    expect_eq("ir_latency", 64'(cyc), 64'(10 * STEP_CLK));
    expect_eq("ir_tck_count", 64'(10'(n_rise - base)), 64'd10);
    expect_eq("ir_tms", hist_vec(1'b0, base, 10), 64'h183);
    expect_eq("ir_tdi", hist_vec(1'b1, base + 10'd4, 4), 64'hA);
    expect_eq("ir_update", 64'(ir_upd), 64'hA);
    expect_eq("ir_tap_rti", 64'(tap), 64'(T_RTI));

    // DR scan, minimum length L=1
    base = n_rise;
    run_cmd(C_DR, 6'd1, 32'h1, rd, re, cyc);
    expect_eq("dr1_rspdata", 64'(rd), 64'h1);
    expect_eq("dr1_tck_count", 64'(10'(n_rise - base)), 64'd6);
    expect_eq("dr1_tms", hist_vec(1'b0, base, 6), 64'h19);
    expect_eq("dr1_update", 64'(bsr_upd), 64'hEF56DF77);

    // DR scan, full length L=MAX_LEN
    base = n_rise;
    run_cmd(C_DR, 6'd32, 32'h12345678, rd, re, cyc);
    expect_eq("dr32_rspdata", 64'(rd), 64'hDEADBEEF);
    expect_eq("dr32_rsperr", 64'(re), 64'd0);
    expect_eq("dr32_latency", 64'(cyc), 64'(37 * STEP_CLK));
    expect_eq("dr32_tms", hist_vec(1'b0, base, 37), 64'hC_0000_0001);
    expect_eq("dr32_update", 64'(bsr_upd), 64'h12345678);
    expect_eq("dr32_tap_rti", 64'(tap), 64'(T_RTI));

    // Illegal lengths: immediate error response, TCK static
    base = n_rise;
    run_cmd(C_DR, 6'd0, 32'h5, rd, re, cyc);
    expect_eq("err0_rsp", 64'({re, rd}), 64'h1_0000_0000);
    expect_eq("err0_latency", 64'(cyc), 64'd0);
    run_cmd(C_DR, 6'd33, 32'h5, rd, re, cyc);
    expect_eq("err33_rsp", 64'({re, rd}), 64'h1_0000_0000);
    expect_eq("err33_latency", 64'(cyc), 64'd0);
    expect_eq("err_no_tck", 64'(10'(n_rise - base)), 64'd0);

    // Idle clocks, L=7
    base = n_rise;
    run_cmd(C_IDLE, 6'd7, 32'hFFFF_FFFF, rd, re, cyc);
    expect_eq("idle_rsp", 64'({re, rd}), 64'd0);
    expect_eq("idle_latency", 64'(cyc), 64'(7 * STEP_CLK));
    expect_eq("idle_tck_count", 64'(10'(n_rise - base)), 64'd7);
    expect_eq("idle_tms_tdi", hist_vec(1'b0, base, 7) | hist_vec(1'b1, base, 7), 64'd0);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (hi_w[base + 10'(i)] != time'(DIV * CLK_NS)) bad++;
      if (i > 0 && (rise_t[base + 10'(i)] - rise_t[base + 10'(i) - 10'd1]) != time'(STEP_CLK * CLK_NS)) bad++;
    end
    expect_eq("idle_tck_timing", 64'(bad), 64'd0);

    // Reset in the middle of a DR shift
    sh0 = n_shift;
    @(negedge Clk);
    CmdType  = C_DR;
    CmdLen   = 6'd32;
    CmdData  = 32'h12345678;
    CmdValid = 1'b1;
    wait_ready("mid_accept");
    @(negedge Clk);
    CmdValid = 1'b0;
    bad = 0;
    while ((n_shift - sh0) < 10 && bad < 2000) begin
      @(negedge Clk);
      bad++;
    end
    expect_eq("mid_shift_reached", 64'(n_shift - sh0), 64'd10);
    rsp0   = n_rsp;
    ResetN = 1'b0;
    #1;
    expect_eq("mid_rst_pins", 64'({TCK, TMS, TDI, CmdReady, RspValid, RspErr}), 64'b010000);
    repeat (2) @(negedge Clk);
    base   = n_rise;
    ResetN = 1'b1;
    wait_ready("mid_ready");
    expect_eq("mid_tck_count", 64'(10'(n_rise - base)), 64'd6);
    expect_eq("mid_tms", hist_vec(1'b0, base, 6), 64'h1F);
    expect_eq("mid_no_rsp", 64'(n_rsp - rsp0), 64'd0);
    expect_eq("mid_tap_rti", 64'(tap), 64'(T_RTI));
    run_cmd(C_IR, 6'd4, 32'h6, rd, re, cyc);
    expect_eq("mid_ir_rsp", 64'({re, rd}), 64'h1);
    expect_eq("mid_ir_update", 64'(ir_upd), 64'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
